// File: rtl/batch_stats_accumulator.sv
// Batch statistics front-end for the batch-norm normalizer: accumulates sum and sum-of-squares
// over 2^LOG2_N samples, then emits mean and variance. Define BATCH_STATS_RUNNING_EN for running stats.
module batch_stats_accumulator #(
    parameter int WIDTH  = 16,
    parameter int FRAC   = 8,
    parameter int LOG2_N = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic                    x_valid,
    output logic                    x_ready,
    output logic signed [WIDTH-1:0] mean,
    output logic        [WIDTH-1:0] variance,
    output logic                    stats_valid,
    output logic       [LOG2_N-1:0] sample_cnt
`ifdef BATCH_STATS_RUNNING_EN
    ,
    output logic signed [WIDTH-1:0] running_mean,
    output logic        [WIDTH-1:0] running_var
`endif
);

    localparam int SUM_W = WIDTH + LOG2_N;
    localparam int SQ_W  = 2 * WIDTH + LOG2_N;
    localparam int EX2_W = 2 * WIDTH - FRAC;
    localparam int D_W   = EX2_W + 1;
    localparam logic signed [D_W-1:0] VAR_MAX = D_W'({WIDTH{1'b1}});

    typedef enum logic [1:0] {
        ACCUM,
        FIN_MEAN,
        FIN_VAR
    } state_t;

    state_t state, state_nxt;

    logic signed [SUM_W-1:0]   sum;
    logic        [SQ_W-1:0]    sumsq;
    logic signed [WIDTH-1:0]   mean_r;
    logic        [EX2_W-1:0]   ex2_r;
    logic                      accept;
    logic signed [2*WIDTH-1:0] x_sq;
    logic signed [2*WIDTH-1:0] mean_sq;
    logic        [EX2_W-1:0]   msq_shift;
    logic signed [D_W-1:0]     diff;
    logic        [WIDTH-1:0]   var_sat;

    // Next state and handshake; clear blocks acceptance so an aborted batch stays empty
    always_comb begin
        state_nxt = state;
        x_ready   = 1'b0;
        accept    = 1'b0;
        case (state)
            ACCUM: begin
                x_ready = !clear;
                accept  = x_valid && !clear;
                if (accept && (&sample_cnt)) begin
                    state_nxt = FIN_MEAN;
                end
            end
            FIN_MEAN: state_nxt = FIN_VAR;
            FIN_VAR:  state_nxt = ACCUM;
            default:  state_nxt = ACCUM;
        endcase
    end

    // Variance = E[x^2] - mean^2, clamped into the unsigned output range
    always_comb begin
        x_sq      = x_in * x_in;
        mean_sq   = mean_r * mean_r;
        msq_shift = EX2_W'(mean_sq >> FRAC);
        diff      = $signed({1'b0, ex2_r}) - $signed({1'b0, msq_shift});
        var_sat   = diff[WIDTH-1:0];
        if (diff[D_W-1]) begin
            var_sat = '0;
        end else if (diff > VAR_MAX) begin
            var_sat = '1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ACCUM;
            sum         <= '0;
            sumsq       <= '0;
            sample_cnt  <= '0;
            mean_r      <= '0;
            ex2_r       <= '0;
            mean        <= '0;
            variance    <= '0;
            stats_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            stats_valid <= 1'b0;
            case (state)
                ACCUM: begin
                    if (clear) begin
                        sum        <= '0;
                        sumsq      <= '0;
                        sample_cnt <= '0;
                    end else if (accept) begin
                        sum        <= sum + SUM_W'(x_in);
                        sumsq      <= sumsq + SQ_W'(unsigned'(x_sq));
                        sample_cnt <= sample_cnt + LOG2_N'(1);
                    end
                end
                FIN_MEAN: begin
                    mean_r <= WIDTH'(sum >>> LOG2_N);
                    ex2_r  <= EX2_W'(sumsq >> (LOG2_N + FRAC));
                    sum    <= '0;
                    sumsq  <= '0;
                end
                FIN_VAR: begin
                    mean        <= mean_r;
                    variance    <= var_sat;
                    stats_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef BATCH_STATS_RUNNING_EN
    localparam logic signed [WIDTH+1:0] RV_MAX = (WIDTH + 2)'({WIDTH{1'b1}});

    logic signed [WIDTH:0]   rm_diff;
    logic signed [WIDTH:0]   rv_diff;
    logic signed [WIDTH+1:0] rm_next;
    logic signed [WIDTH+1:0] rv_next;

    // Exponential moving average with momentum 1/8 toward each new batch result
    always_comb begin
        rm_diff = {mean_r[WIDTH-1], mean_r} - {running_mean[WIDTH-1], running_mean};
        rv_diff = $signed({1'b0, var_sat}) - $signed({1'b0, running_var});
        rm_next = (WIDTH + 2)'(running_mean) + (WIDTH + 2)'(rm_diff >>> 3);
        rv_next = $signed({2'b00, running_var}) + (WIDTH + 2)'(rv_diff >>> 3);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            running_mean <= '0;
            running_var  <= WIDTH'(1 << FRAC);
        end else if (state == FIN_VAR) begin
            running_mean <= WIDTH'(rm_next);
            if (rv_next < 0) begin
                running_var <= '0;
            end else if (rv_next > RV_MAX) begin
                running_var <= '1;
            end else begin
                running_var <= WIDTH'(rv_next);
            end
        end
    end
`endif

endmodule
